// File: rtl/mult_pkg.sv
// Shared constants and helpers for the shift-add multiplier (FSM, datapath, bench).
package mult_pkg;

    // Default operand width in bits.
    localparam int MULT_WIDTH = 8;

    // Width of a step counter that must hold values 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Loadable down-counter that saturates at zero and flags the 1->0 transition.
module mult_step_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          zero,
    output logic          last_pulse
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          last_reg;
    logic          last_next;

    // Next count: load wins, decrement only when non-zero so the count never wraps.
    always_comb begin
        cnt_next  = cnt_reg;
        last_next = 1'b0;
        if (load) begin
            cnt_next = load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_next  = cnt_reg - 1'b1;
            last_next = (cnt_reg == CW'(1));
        end
    end

    // Count and one-cycle completion flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            last_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            last_reg <= last_next;
        end
    end

    assign cnt        = cnt_reg;
    assign zero       = (cnt_reg == '0);
    assign last_pulse = last_reg;

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand/accumulator registers, adder, step counter.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               shift,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               stop,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic             c_reg, c_next;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    cnt;
    logic             zero;
    logic             step;

    mult_step_counter #(
        .CW(CW)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (en),
        .dec        (shift),
        .load_val   (CW'(WIDTH)),
        .cnt        (cnt),
        .zero       (zero),
        .last_pulse (done)
    );

    // A step happens only when not loading and steps remain; extra shifts are ignored.
    assign step = shift && !en && (cnt != '0);

    // Adder plus load/step selection. C is zero between steps, so {C,A} is the
    // accumulator extended by one bit and the sum MSB lands in A's top bit.
    always_comb begin
        sum    = {c_reg, a_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
        m_next = m_reg;
        q_next = q_reg;
        a_next = a_reg;
        c_next = c_reg;
        if (en) begin
            m_next = a_in;
            q_next = b_in;
            a_next = '0;
            c_next = 1'b0;
        end else if (step) begin
            c_next = 1'b0;
            a_next = sum[WIDTH:1];
            q_next = {sum[0], q_reg[WIDTH-1:1]};
        end
    end

    // Operand, accumulator and carry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg <= '0;
            q_reg <= '0;
            a_reg <= '0;
            c_reg <= 1'b0;
        end else begin
            m_reg <= m_next;
            q_reg <= q_next;
            a_reg <= a_next;
            c_reg <= c_next;
        end
    end

    assign stop    = zero;
    assign product = {a_reg, q_reg};

endmodule
